// File: rtl/psram_line_cache.sv
// Direct-mapped write-back, write-allocate cache between a 32-bit CPU port and a
// 64-bit, 4-beat burst RAM controller. One cache line holds exactly one burst.
module psram_line_cache #(
    parameter int LineIndexBitWidth  = 1,
    parameter int RamAddressBitWidth = 4,
    parameter int RamAddressingMode  = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [3:0]                    write_enable,
    input  logic [31:0]                   address,
    output logic [31:0]                   data_out,
    output logic                          data_out_ready,
    input  logic [31:0]                   data_in,
    output logic                          busy,
    output logic                          br_cmd,
    output logic                          br_cmd_en,
    output logic [RamAddressBitWidth-1:0] br_addr,
    output logic [63:0]                   br_wr_data,
    output logic [7:0]                    br_data_mask,
    input  logic [63:0]                   br_rd_data,
    input  logic                          br_rd_data_valid
);
    localparam int TagBitWidth = RamAddressBitWidth + RamAddressingMode - 5 - LineIndexBitWidth;
    localparam int LineCount   = 1 << LineIndexBitWidth;
    localparam int AddrTop     = 5 + LineIndexBitWidth + TagBitWidth;

    typedef enum logic [2:0] {IDLE, WB_CMD, WB_DATA, RD_CMD, RD_WAIT} state_t;
    state_t state;

    logic [LineCount-1:0]         valid;
    logic [LineCount-1:0]         dirty;
    logic [TagBitWidth-1:0]       tags      [LineCount];
    logic [255:0]                 line_data [LineCount];
    logic [LineIndexBitWidth-1:0] req_index;
    logic [TagBitWidth-1:0]       req_tag;
    logic [1:0]                   beat_cnt;
    logic [1:0]                   next_beat;

    logic [LineIndexBitWidth-1:0] cur_index;
    logic [TagBitWidth-1:0]       cur_tag;
    logic [2:0]                   cur_word;
    logic                         hit;
    logic                         write_hit;
    logic                         unused_address;

    assign cur_index      = address[5 +: LineIndexBitWidth];
    assign cur_tag        = address[5 + LineIndexBitWidth +: TagBitWidth];
    assign cur_word       = address[4:2];
    assign unused_address = ^{address[1:0], address[31:AddrTop]};
    assign hit            = valid[cur_index] && (tags[cur_index] == cur_tag);
    assign write_hit      = (state == IDLE) && enable && hit && (write_enable != 4'b0000);
    assign next_beat      = beat_cnt + 2'd1;

    // Requester handshake: a request is presented while enable is high and is
    // accepted in a cycle where busy is low; while busy is high the requester
    // holds address, write_enable and data_in stable.
    assign busy           = (state != IDLE) || (enable && !hit);
    assign data_out_ready = (state == IDLE) && enable && hit && (write_enable == 4'b0000);
    assign data_out       = line_data[cur_index][{cur_word, 5'd0} +: 32];
    assign br_data_mask   = 8'h00;

    function automatic logic [RamAddressBitWidth-1:0] line_addr(
        input logic [TagBitWidth-1:0]       t,
        input logic [LineIndexBitWidth-1:0] i
    );
        return RamAddressBitWidth'({t, i, 2'b00});
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            valid      <= '0;
            dirty      <= '0;
            br_cmd_en  <= 1'b0;
            br_cmd     <= 1'b0;
            br_addr    <= '0;
            br_wr_data <= '0;
            beat_cnt   <= '0;
            req_index  <= '0;
            req_tag    <= '0;
            for (int i = 0; i < LineCount; i++) tags[i] <= '0;
        end else begin
            br_cmd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        if (hit) begin
                            if (write_enable != 4'b0000) dirty[cur_index] <= 1'b1;
                        end else begin
                            req_index <= cur_index;
                            req_tag   <= cur_tag;
                            br_cmd_en <= 1'b1;
                            // Dirty victim goes out first, beat 0 alongside the command.
                            if (valid[cur_index] && dirty[cur_index]) begin
                                state      <= WB_CMD;
                                br_cmd     <= 1'b1;
                                br_addr    <= line_addr(tags[cur_index], cur_index);
                                br_wr_data <= line_data[cur_index][63:0];
                            end else begin
                                state   <= RD_CMD;
                                br_cmd  <= 1'b0;
                                br_addr <= line_addr(cur_tag, cur_index);
                            end
                        end
                    end
                end
                WB_CMD: begin
                    beat_cnt   <= 2'd1;
                    br_wr_data <= line_data[req_index][127:64];
                    state      <= WB_DATA;
                end
                WB_DATA: begin
                    if (beat_cnt == 2'd3) begin
                        dirty[req_index] <= 1'b0;
                        br_cmd_en        <= 1'b1;
                        br_cmd           <= 1'b0;
                        br_addr          <= line_addr(req_tag, req_index);
                        state            <= RD_CMD;
                    end else begin
                        beat_cnt   <= next_beat;
                        br_wr_data <= line_data[req_index][{next_beat, 6'd0} +: 64];
                    end
                end
                RD_CMD: begin
                    beat_cnt <= 2'd0;
                    state    <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (br_rd_data_valid) begin
                        beat_cnt <= next_beat;
                        if (beat_cnt == 2'd3) begin
                            valid[req_index] <= 1'b1;
                            dirty[req_index] <= 1'b0;
                            tags[req_index]  <= req_tag;
                            state            <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage has no reset; valid bits guard its contents.
    always_ff @(posedge clk) begin
        if (rst_n && write_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (write_enable[b]) line_data[cur_index][{cur_word, 5'd0} + 8 * b +: 8] <= data_in[8 * b +: 8];
            end
        end else if (rst_n && (state == RD_WAIT) && br_rd_data_valid) begin
            line_data[req_index][{beat_cnt, 6'd0} +: 64] <= br_rd_data;
        end
    end
endmodule

// File: tb/tb_psram_line_cache.sv
// Directed bench for psram_line_cache with a behavioural burst RAM responder.
module tb_psram_line_cache;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  write_enable = 4'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] data_out;
    logic        data_out_ready;
    logic [31:0] data_in = 32'h0;
    logic        busy;
    logic        br_cmd;
    logic        br_cmd_en;
    logic [3:0]  br_addr;
    logic [63:0] br_wr_data;
    logic [7:0]  br_data_mask;
    logic [63:0] br_rd_data = 64'h0;
    logic        br_rd_data_valid = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [63:0] ram [16];
    int          rd_cmd_count = 0;
    int          wb_cmd_count = 0;
    logic [3:0]  last_rd_addr = 4'hF;
    logic [3:0]  last_wb_addr = 4'hF;

    psram_line_cache dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .write_enable(write_enable),
        .address(address), .data_out(data_out), .data_out_ready(data_out_ready),
        .data_in(data_in), .busy(busy), .br_cmd(br_cmd), .br_cmd_en(br_cmd_en),
        .br_addr(br_addr), .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
        .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // burst RAM responder: writes capture 4 beats, reads answer after 3 cycles
    initial begin : ram_model
        logic [3:0] a;
        forever begin
            @(posedge clk);
            if (rst_n === 1'b1 && br_cmd_en === 1'b1) begin
                a = br_addr;
                if (br_cmd) begin
                    wb_cmd_count++;
                    last_wb_addr = a;
                    ram[a] = br_wr_data;
                    for (int i = 1; i < 4; i++) begin
                        @(posedge clk);
                        a = a + 4'd1;
                        ram[a] = br_wr_data;
                    end
                end else begin
                    rd_cmd_count++;
                    last_rd_addr = a;
                    repeat (3) @(negedge clk);
                    for (int i = 0; i < 4; i++) begin
                        br_rd_data = ram[a];
                        br_rd_data_valid = 1'b1;
                        a = a + 4'd1;
                        @(negedge clk);
                    end
                    br_rd_data_valid = 1'b0;
                end
            end
        end
    end

    // driver tasks
    task automatic drive(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        @(negedge clk);
        enable = 1'b1;
        address = a;
        write_enable = we;
        data_in = d;
        #1;
    endtask

    task automatic wait_idle(output bit ok, output bit ready_while_busy);
        ready_while_busy = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (!busy) break;
            if (data_out_ready) ready_while_busy = 1'b1;
            @(negedge clk);
            #1;
        end
        ok = !busy;
    endtask

    // tests
    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (data_out_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", data_out_ready); end
        checks++; if (br_cmd_en !== 1'b0) begin failures++; $display("FAIL reset_cmd_en got=%b exp=0", br_cmd_en); end
        checks++; if (br_cmd !== 1'b0) begin failures++; $display("FAIL reset_cmd got=%b exp=0", br_cmd); end
        checks++; if (br_data_mask !== 8'h00) begin failures++; $display("FAIL reset_mask got=%h exp=00", br_data_mask); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read_miss_fill();
        bit ok, rwb;
        int n_rd = rd_cmd_count;
        int n_wb = wb_cmd_count;
        drive(32'd16, 4'b0000, 32'h0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rd16_busy got=%b exp=1", busy); end
        checks++; if (data_out_ready !== 1'b0) begin failures++; $display("FAIL rd16_ready_early got=%b exp=0", data_out_ready); end
        wait_idle(ok, rwb);
        checks++; if (!ok) begin failures++; $display("FAIL rd16_timeout busy=%b exp=0", busy); end
        checks++; if (rwb) begin failures++; $display("FAIL rd16_ready_during_fill got=1 exp=0"); end
        checks++; if (data_out_ready !== 1'b1) begin failures++; $display("FAIL rd16_ready got=%b exp=1", data_out_ready); end
        checks++; if (data_out !== 32'hD5B8A9C4) begin failures++; $display("FAIL rd16_data got=%h exp=D5B8A9C4", data_out); end
        checks++; if (rd_cmd_count !== n_rd + 1) begin failures++; $display("FAIL rd16_rd_cmds got=%0d exp=%0d", rd_cmd_count, n_rd + 1); end
        checks++; if (last_rd_addr !== 4'd0) begin failures++; $display("FAIL rd16_br_addr got=%0d exp=0", last_rd_addr); end
        checks++; if (wb_cmd_count !== n_wb) begin failures++; $display("FAIL rd16_wb_cmds got=%0d exp=%0d", wb_cmd_count, n_wb); end
    endtask

    task automatic test_read_hits();
        bit ok, rwb;
        drive(32'd8, 4'b0000, 32'h0);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rd8_busy got=%b exp=0", busy); end
        checks++; if (data_out_ready !== 1'b1) begin failures++; $display("FAIL rd8_ready got=%b exp=1", data_out_ready); end
        checks++; if (data_out !== 32'hAB4C3E6F) begin failures++; $display("FAIL rd8_data got=%h exp=AB4C3E6F", data_out); end
        drive(32'd32, 4'b0000, 32'h0);
        checks++; if (data_out_ready !== 1'b0) begin failures++; $display("FAIL rd32_ready_early got=%b exp=0", data_out_ready); end
        wait_idle(ok, rwb);
        checks++; if (!ok || rwb) begin failures++; $display("FAIL rd32_fill ok=%b ready_while_busy=%b exp=1/0", ok, rwb); end
        checks++; if (last_rd_addr !== 4'd4) begin failures++; $display("FAIL rd32_br_addr got=%0d exp=4", last_rd_addr); end
        checks++; if (data_out !== 32'h2F5E3C7A || data_out_ready !== 1'b1) begin failures++; $display("FAIL rd32_data got=%h/%b exp=2F5E3C7A/1", data_out, data_out_ready); end
        drive(32'd12, 4'b0000, 32'h0);
        checks++; if (data_out !== 32'h9D8E2F17 || data_out_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rd12 got=%h/%b/%b exp=9D8E2F17/1/0", data_out, data_out_ready, busy); end
    endtask

    task automatic test_byte_writes();
        logic [3:0]  we_v  [3] = '{4'b0001, 4'b0011, 4'b1100};
        logic [31:0] din_v [3] = '{32'h000000AD, 32'h00008765, 32'hFEEF0000};
        logic [31:0] exp_v [3] = '{32'hAB4C3EAD, 32'hAB4C8765, 32'hFEEF8765};
        for (int i = 0; i < 3; i++) begin
            drive(32'd8, we_v[i], din_v[i]);
            checks++; if (busy !== 1'b0 || data_out_ready !== 1'b0) begin failures++; $display("FAIL bytewr%0d_busy got=%b/%b exp=0/0", i, busy, data_out_ready); end
            drive(32'd8, 4'b0000, 32'h0);
            checks++; if (data_out !== exp_v[i] || data_out_ready !== 1'b1) begin failures++; $display("FAIL bytewr%0d_read got=%h/%b exp=%h/1", i, data_out, data_out_ready, exp_v[i]); end
        end
    endtask

    task automatic test_write_miss_evict();
        bit ok, rwb;
        logic [63:0] w;
        int n_wb = wb_cmd_count;
        drive(32'd64, 4'b1111, 32'hABCDEF12);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr64_busy got=%b exp=1", busy); end
        wait_idle(ok, rwb);
        checks++; if (!ok) begin failures++; $display("FAIL wr64_timeout busy=%b exp=0", busy); end
        checks++; if (wb_cmd_count !== n_wb + 1 || last_wb_addr !== 4'd0) begin failures++; $display("FAIL wr64_wb got=%0d@%0d exp=%0d@0", wb_cmd_count, last_wb_addr, n_wb + 1); end
        checks++; if (last_rd_addr !== 4'd8) begin failures++; $display("FAIL wr64_rd_addr got=%0d exp=8", last_rd_addr); end
        w = ram[1];
        checks++; if (w !== 64'h9D8E2F17FEEF8765) begin failures++; $display("FAIL wr64_wb_data got=%h exp=9D8E2F17FEEF8765", w); end
        drive(32'd64, 4'b0000, 32'h0);
        checks++; if (data_out !== 32'hABCDEF12 || data_out_ready !== 1'b1) begin failures++; $display("FAIL rd64 got=%h/%b exp=ABCDEF12/1", data_out, data_out_ready); end
        drive(32'd64, 4'b1111, 32'h1B2D3F42);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr64_hit_busy got=%b exp=0", busy); end
        drive(32'd64, 4'b0000, 32'h0);
        checks++; if (data_out !== 32'h1B2D3F42 || data_out_ready !== 1'b1) begin failures++; $display("FAIL rd64_hit got=%h/%b exp=1B2D3F42/1", data_out, data_out_ready); end
    endtask

    task automatic test_back_to_back();
        bit ok, rwb;
        logic [63:0] w;
        drive(32'd0, 4'b1111, 32'h11223344);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr0_busy got=%b exp=1", busy); end
        wait_idle(ok, rwb);
        checks++; if (!ok || last_wb_addr !== 4'd8 || last_rd_addr !== 4'd0) begin failures++; $display("FAIL wr0_bursts ok=%b wb=%0d rd=%0d exp=1/8/0", ok, last_wb_addr, last_rd_addr); end
        w = ram[8];
        checks++; if (w[31:0] !== 32'h1B2D3F42) begin failures++; $display("FAIL wr0_wb_data got=%h exp=1B2D3F42", w[31:0]); end
        drive(32'd8, 4'b0000, 32'h0);
        checks++; if (data_out !== 32'hFEEF8765 || data_out_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rd8_refetch got=%h/%b/%b exp=FEEF8765/1/0", data_out, data_out_ready, busy); end
        drive(32'd28, 4'b0000, 32'h0);
        checks++; if (data_out !== 32'h7D4E9F2C || data_out_ready !== 1'b1) begin failures++; $display("FAIL rd28 got=%h/%b exp=7D4E9F2C/1", data_out, data_out_ready); end
        drive(32'd0, 4'b0000, 32'h0);
        checks++; if (data_out !== 32'h11223344 || data_out_ready !== 1'b1) begin failures++; $display("FAIL rd0_after_write got=%h/%b exp=11223344/1", data_out, data_out_ready); end
    endtask

    task automatic test_reset_mid_burst();
        bit ok, rwb;
        int n_rd = rd_cmd_count;
        drive(32'd96, 4'b0000, 32'h0);
        for (int c = 0; c < 20 && rd_cmd_count == n_rd; c++) @(negedge clk);
        checks++; if (rd_cmd_count !== n_rd + 1 || last_rd_addr !== 4'd12) begin failures++; $display("FAIL rd96_cmd got=%0d@%0d exp=%0d@12", rd_cmd_count, last_rd_addr, n_rd + 1); end
        @(negedge clk);
        rst_n = 1'b0;
        enable = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || data_out_ready !== 1'b0) begin failures++; $display("FAIL midrst_idle got=%b/%b exp=0/0", busy, data_out_ready); end
        drive(32'd8, 4'b0000, 32'h0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_invalidated busy=%b exp=1", busy); end
        wait_idle(ok, rwb);
        checks++; if (!ok || data_out !== 32'hFEEF8765 || data_out_ready !== 1'b1) begin failures++; $display("FAIL midrst_rd8 got=%h/%b exp=FEEF8765/1", data_out, data_out_ready); end
        drive(32'd0, 4'b0000, 32'h0);
        checks++; if (data_out !== 32'h00000000 || data_out_ready !== 1'b1) begin failures++; $display("FAIL midrst_dirty_lost got=%h/%b exp=00000000/1", data_out, data_out_ready); end
        @(negedge clk);
        enable = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || data_out_ready !== 1'b0) begin failures++; $display("FAIL idle_disabled got=%b/%b exp=0/0", busy, data_out_ready); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 64'h0;
        ram[1] = 64'h9D8E2F17AB4C3E6F;
        ram[2] = 64'h00000000D5B8A9C4;
        ram[3] = 64'h7D4E9F2C00000000;
        ram[4] = 64'h000000002F5E3C7A;
        test_reset();
        test_read_miss_fill();
        test_read_hits();
        test_byte_writes();
        test_write_miss_evict();
        test_back_to_back();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
